// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, memory-unit state encoding and opcode constants
package cpu_pkg;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    typedef enum logic [1:0] {CLEAR, RUN, PROG, DONE} mem_state_t;
    localparam logic [3:0] LDA = 4'h1;
    localparam logic [3:0] ADD = 4'h2;
    localparam logic [3:0] SUB = 4'h3;
    localparam logic [3:0] OUT = 4'hE;
    localparam logic [3:0] HLT = 4'hF;
endpackage

// File: rtl/ram_array.sv
// ram_array: storage with one synchronous write port and one asynchronous read port
module ram_array #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/memory_unit.sv
// memory_unit: MAR plus program/data RAM with post-reset clear and host program loading
module memory_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_load,
    input  logic              ram_out,
    output logic [DATA_W-1:0] ram_dout,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mar_q
);
    import cpu_pkg::*;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d, mar_d;
    logic              we;
    logic [DATA_W-1:0] wdata, rdata;
    logic              unused_bus;
    assign unused_bus = ^bus_in[DATA_W-1:ADDR_W];
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        wptr_d  = wptr_q;
        we      = 1'b0;
        wdata   = '0;
        case (state_q)
            CLEAR: begin
                we     = 1'b1;
                wptr_d = wptr_q + 1'b1;
                if (wptr_q == LAST) state_d = RUN;
            end
            RUN: begin
                if (mar_load) mar_d = bus_in[ADDR_W-1:0];
                if (prog_mode) begin
                    state_d = PROG;
                    wptr_d  = '0;
                end
            end
            PROG: begin
                if (prog_valid) begin
                    we     = 1'b1;
                    wdata  = prog_data;
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == LAST) state_d = DONE;
                end
                // abort wins over completion; the byte in flight is still written
                if (!prog_mode) begin
                    state_d = RUN;
                    wptr_d  = '0;
                    mar_d   = '0;
                end
            end
            DONE: begin
                if (!prog_mode) begin
                    state_d = RUN;
                    mar_d   = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            mar_q   <= '0;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            wptr_q  <= wptr_d;
        end
    end
    ram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (mar_q),
        .rdata (rdata)
    );
    assign cpu_stall  = state_q != RUN;
    assign prog_ready = state_q == PROG;
    assign prog_done  = state_q == DONE;
    assign ram_dout   = (state_q == RUN && ram_out) ? rdata : '0;
endmodule
